// File: rtl/risc_loader.sv
// Program loader for a small CPU core: streams bytes into program memory,
// then releases the core from reset and counts its run cycles until halt.
module risc_loader #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              cpu_rst,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cycles
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    // Memory depth; a longer requested program is truncated to this.
    localparam logic [AWIDTH:0] MaxLen = {1'b1, {AWIDTH{1'b0}}};

    state_e              state_q, state_d;
    logic [AWIDTH:0]     eff_len_q, eff_len_d;
    logic [AWIDTH:0]     cnt_q, cnt_d;
    logic [AWIDTH:0]     cnt_inc;
    logic                mem_wr_q, mem_wr_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_data_q, mem_data_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic [15:0]         cycles_q, cycles_d;
    logic                start_acc;

    assign cnt_inc = cnt_q + (AWIDTH+1)'(1);

    // Next-state, memory write and cycle-counter logic.
    always_comb begin
        state_d    = state_q;
        eff_len_d  = eff_len_q;
        cnt_d      = cnt_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cycles_d   = cycles_q;
        start_acc  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_acc = 1'b1;
                    eff_len_d = (len > MaxLen) ? MaxLen : len;
                    cnt_d     = '0;
                    cycles_d  = '0;
                    state_d   = (len == '0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                // in_ready is high throughout LOAD, so in_valid alone means a transfer.
                if (in_valid) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cnt_q[AWIDTH-1:0];
                    mem_data_d = in_data;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == eff_len_q) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Halt only counts once the core is actually out of reset.
                if (!cpu_rst_q) begin
                    if (halt) begin
                        state_d = StDone;
                    end else if (cycles_q != 16'hFFFF) begin
                        cycles_d = cycles_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // One-cycle lag into RUN lets the final memory write land first.
        cpu_rst_d = !(((state_q == StRun) || (state_q == StDone)) && !start_acc);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            eff_len_q  <= '0;
            cnt_q      <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            eff_len_q  <= eff_len_d;
            cnt_q      <= cnt_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            cycles_q   <= cycles_d;
        end
    end

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q == StLoad) || (state_q == StRun);
    assign done     = (state_q == StDone);
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_risc_loader.sv
// Directed testbench for risc_loader with hand-computed expectations.
module tb_risc_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_rst;
    logic        halt;
    logic        busy;
    logic        done;
    logic [15:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] wr_addr[$];
    logic [7:0] wr_data[$];

    risc_loader #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .halt     (halt),
        .busy     (busy),
        .done     (done),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start(input logic [5:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for the core to leave reset, then halt it.
    task automatic halt_run();
        int k = 0;
        while (cpu_rst !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check("cpu_rst_fall", {31'd0, cpu_rst}, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("done_after_halt", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        halt     = 1'b0;

        // Reset values.
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_wr",   {31'd0, mem_wr},   32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, mem_data}, 32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_cycles",   {16'd0, cycles},   32'd0);
        rst = 1'b1;
        tick();

        // Basic load; in_valid already high alongside start must not transfer.
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'hA0;
        do_start(6'd3);
        check("load_in_ready", {31'd0, in_ready}, 32'd1);
        check("load_busy",     {31'd0, busy},     32'd1);
        check("load_mem_wr0",  {31'd0, mem_wr},   32'd0);
        tick();
        check("b0_mem_wr",   {31'd0, mem_wr},   32'd1);
        check("b0_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("b0_mem_data", {24'd0, mem_data}, 32'hA0);
        in_data = 8'hA1;
        tick();
        in_data = 8'hA2;
        tick();
        in_valid = 1'b0;
        check("b2_in_ready", {31'd0, in_ready}, 32'd0);
        check("b2_mem_addr", {27'd0, mem_addr}, 32'd2);
        check("b2_mem_data", {24'd0, mem_data}, 32'hA2);
        check("run1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        tick();
        check("run2_cpu_rst", {31'd0, cpu_rst},  32'd0);
        check("run2_mem_wr",  {31'd0, mem_wr},   32'd0);
        check("hold_addr",    {27'd0, mem_addr}, 32'd2);
        check("hold_data",    {24'd0, mem_data}, 32'hA2);
        check("run2_cycles",  {16'd0, cycles},   32'd0);
        check("basic_nwr", wr_addr.size(), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check("basic_addr", {27'd0, wr_addr[i]}, i);
            check("basic_data", {24'd0, wr_data[i]}, 32'hA0 + i);
        end

        // Run for 10 cycles, then halt.
        for (int i = 0; i < 10; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_done",    {31'd0, done},    32'd1);
        check("halt_busy",    {31'd0, busy},    32'd0);
        check("halt_cycles",  {16'd0, cycles},  32'd10);
        check("halt_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        tick();
        tick();
        check("frozen_cycles", {16'd0, cycles}, 32'd10);

        // Restart from DONE with a stalling stream: valid 1,0,0,1.
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'hB0;
        do_start(6'd2);
        check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("restart_cycles",  {16'd0, cycles},  32'd0);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        check("st1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("st2_in_ready", {31'd0, in_ready}, 32'd1);
        check("st2_mem_wr",   {31'd0, mem_wr},   32'd0);
        tick();
        check("st3_in_ready", {31'd0, in_ready}, 32'd1);
        check("st3_hold_data", {24'd0, mem_data}, 32'hB0);
        in_valid = 1'b1;
        in_data  = 8'hB1;
        tick();
        in_valid = 1'b0;
        check("st4_in_ready", {31'd0, in_ready}, 32'd0);
        check("st4_mem_addr", {27'd0, mem_addr}, 32'd1);
        check("st4_mem_data", {24'd0, mem_data}, 32'hB1);
        tick();
        check("stall_nwr", wr_addr.size(), 32'd2);
        halt_run();

        // len=0 goes straight to RUN; halt during cpu_rst=1 is ignored.
        clear_log();
        halt = 1'b1;
        do_start(6'd0);
        check("len0_busy",     {31'd0, busy},     32'd1);
        check("len0_in_ready", {31'd0, in_ready}, 32'd0);
        check("len0_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        tick();
        halt = 1'b0;
        check("len0_halt_ign", {31'd0, done},    32'd0);
        check("len0_cpu_rst2", {31'd0, cpu_rst}, 32'd0);
        halt_run();
        check("len0_nwr", wr_addr.size(), 32'd0);

        // len=40 truncates to 32 bytes.
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'h40;
        do_start(6'd40);
        for (int i = 0; i < 32; i++) begin
            tick();
            in_data = 8'h41 + 8'(i);
        end
        in_valid = 1'b0;
        check("len40_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("len40_nwr", wr_addr.size(), 32'd32);
        for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
            check("len40_addr", {27'd0, wr_addr[i]}, i);
            check("len40_data", {24'd0, wr_data[i]}, 32'h40 + i);
        end
        halt_run();

        // Abort with reset while the second byte's write is on the bus.
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'hC0;
        do_start(6'd4);
        tick();
        in_data = 8'hC1;
        tick();
        check("abort_wr_live", {31'd0, mem_wr}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_mem_wr",   {31'd0, mem_wr},   32'd0);
        check("abort_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("abort_busy",     {31'd0, busy},     32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("abort_nwr", wr_addr.size(), 32'd2);

        // Saturating cycle counter; start during RUN is ignored.
        do_start(6'd0);
        tick();
        check("sat_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        for (int i = 0; i < 100; i++) tick();
        do_start(6'd3);
        check("run_start_ign_busy",   {31'd0, busy},     32'd1);
        check("run_start_ign_ready",  {31'd0, in_ready}, 32'd0);
        check("run_start_ign_cycles", {16'd0, cycles},   32'd101);
        for (int i = 0; i < 65500; i++) tick();
        check("sat_cycles", {16'd0, cycles}, 32'hFFFF);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("sat_done",        {31'd0, done},   32'd1);
        check("sat_done_cycles", {16'd0, cycles}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_loader.md
RISC_LOADER -- requirements
Module: risc_loader

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to load a program and run it.
REQ-006 SHALL have port len  input  AWIDTH+1  byte count for the program, sampled with start.
REQ-007 SHALL have port in_valid  input  1  program byte valid.
REQ-008 SHALL have port in_data  input  DWIDTH  program byte.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_wr  output  1  memory write strobe.
REQ-011 SHALL have port mem_addr  output  AWIDTH  memory write address.
REQ-012 SHALL have port mem_data  output  DWIDTH  memory write data.
REQ-013 SHALL have port cpu_rst  output  1  active-high reset to the CPU core.
REQ-014 SHALL have port halt  input  1  halt from the CPU core.
REQ-015 SHALL have port busy  output  1  high in LOAD or RUN.
REQ-016 SHALL have port done  output  1  high in DONE.
REQ-017 SHALL have port cycles  output  16  number of CPU run cycles, saturating.

Function
REQ-018 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-019 IDLE, start=1: SHALL latch eff_len = min(len, 2^AWIDTH), clear the byte count and cycles, and go to LOAD; if len=0 it SHALL go directly to RUN.
REQ-020 in_ready SHALL be 1 exactly while the state is LOAD; a byte transfers when in_valid=1 and in_ready=1 in the same cycle.
REQ-021 Each transfer SHALL produce, on the next cycle, mem_wr=1 for exactly one cycle, with mem_addr = byte index (0, 1, 2, ...) and mem_data = in_data.
REQ-022 mem_addr and mem_data SHALL hold their last values while mem_wr=0.
REQ-023 When the transfer of byte eff_len-1 occurs, the next state SHALL be RUN and in_ready SHALL be 0 from the next cycle.
REQ-024 in_valid=0 in LOAD SHALL stall the loader with no timeout.
REQ-025 cpu_rst SHALL be a registered output: 1 in IDLE and LOAD, 0 from the second cycle of RUN onward, so the final write completes before the CPU leaves reset.
REQ-026 cycles SHALL increment by 1 each cycle with state RUN, cpu_rst=0 and halt=0, and SHALL saturate at 16'hFFFF without wrapping.
REQ-027 RUN, halt=1 while cpu_rst=0: SHALL go to DONE with cycles frozen; halt while cpu_rst=1 SHALL be ignored.
REQ-028 DONE: cpu_rst SHALL stay 0 (CPU stays halted) and done=1; start=1 SHALL behave as in REQ-019, with cpu_rst returning to 1 on the next cycle.
REQ-029 start SHALL be ignored in LOAD and RUN.
REQ-030 start together with in_valid in IDLE SHALL NOT accept a byte.

Reset
REQ-031 When rst=0 at a clock edge, the block SHALL take state IDLE, in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, cpu_rst=1, busy=0, done=0, cycles=0, and clear the byte count.
REQ-032 Reset SHALL take priority over all other inputs and SHALL abort LOAD or RUN mid-operation, including during a mem_wr cycle; the write is dropped from the next edge.

Verification
REQ-033 Reset: rst=0 for 2 cycles -> every output equals the REQ-031 values.
REQ-034 Basic load: start with len=3, bytes A0, A1, A2 with in_valid held high -> mem_wr pulses at addresses 0, 1, 2 with those data; RUN entered; cpu_rst=0 one cycle later.
REQ-035 Stall: in_valid toggling 1, 0, 0, 1 with len=2 -> exactly 2 writes; in_ready stays 1 until the second transfer.
REQ-036 Length limits: len=0 -> no mem_wr and direct RUN; len=40 -> exactly 32 writes at addresses 0..31.
REQ-037 Run and count: halt asserted 10 cycles after cpu_rst=0 -> DONE, cycles=10, done=1; halt held past 65535 run cycles -> cycles=16'hFFFF.
REQ-038 Abort: rst=0 during the second byte of a len=4 load -> IDLE, cpu_rst=1, no further mem_wr.
